// File: rtl/msk_col_fifo_ctrl.sv
// Four-entry in-order buffer for masked AES state columns.
// Control state is share-independent; storage is enable-only registers.
module msk_col_fifo_ctrl #(
  parameter int d     = 2,
  parameter int count = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [count*d-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [count*d-1:0] out_data,
  output logic [1:0]         out_col,
  output logic               out_last,
  output logic [2:0]         level
);

  localparam int W = count * d;
  localparam logic [2:0] LV_FULL = 3'(DEPTH);

  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [1:0] r_col;
  logic [2:0] r_level;

  logic [W-1:0] r_mem [4];

  logic         w_clr;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [3:0]   w_en;
  logic [W-1:0] w_lo;
  logic [W-1:0] w_hi;

  assign w_clr   = !nrst || flush;
  assign w_full  = (r_level == LV_FULL);
  assign w_empty = (r_level == 3'd0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_col   = r_col;
  assign out_last  = !w_empty && (r_col == 2'd3);
  assign level     = r_level;

  // Per-entry write enable: only the slot at wr_ptr, never while clearing
  always_comb begin
    w_en = 4'b0000;
    if (w_push && !w_clr) begin
      w_en[r_wr_ptr] = 1'b1;
    end
  end

  // Control state: pointers, occupancy and column counter
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_col    <= 2'd0;
      r_level  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        r_col    <= r_col + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Masked storage: enable-only registers, shares copied bit-for-bit
  for (genvar g = 0; g < 4; g++) begin : g_ent
    always_ff @(posedge clk) begin
      if (w_en[g]) begin
        r_mem[g] <= in_data;
      end
    end
  end

  // Read mux tree selected only by rd_ptr
  always_comb begin
    w_lo     = r_rd_ptr[0] ? r_mem[1] : r_mem[0];
    w_hi     = r_rd_ptr[0] ? r_mem[3] : r_mem[2];
    out_data = r_rd_ptr[1] ? w_hi : w_lo;
  end

endmodule

// File: doc/msk_col_fifo_ctrl.md
Name: msk_col_fifo_ctrl

Overview:
- Four-entry in-order buffer for masked 32-bit AES state columns, between the key/plaintext share loader and the 32-bit HPC2 S-box datapath.
- Storage is built only from masked enabled registers, one per entry. This block generates their per-entry enables and the read-select from share-independent control state.
- Upstream and downstream each have a valid/ready handshake. Also emits the column index within the 128-bit state and a flag on the last column.

Parameters:
- d, 2, number of shares (masking order d-1); minimum 2.
- count, 32, bits per column; data buses are count*d wide, share-interleaved as in all masked gadgets.
- DEPTH, 4, entries; fixed at 4 (one full AES state); other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  synchronous reset, active-low.
- flush  in  1  synchronous clear of control state; same effect as reset.
- in_valid  in  1  upstream column valid.
- in_ready  out  1  buffer can accept a column.
- in_data  in  count*d  masked column, shares interleaved.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  count*d  masked head column.
- out_col  out  2  column index (0..3) of head within current state.
- out_last  out  1  high when out_col==3 and out_valid.
- level  out  3  occupancy, 0..4.

Behaviour:
- Reset and flush: while nrst==0 or flush==1 at a clock edge, the following are cleared.
  - wr_ptr=0, rd_ptr=0, level=0, out_col counter=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, level=0, out_col=0.
  - out_data is unspecified but stable.
  - Data registers are not reset (masked registers carry no reset). Stale shares stay in storage but are never presented as valid.
- nrst has priority over all handshakes. An in-progress push or pop in the reset cycle is discarded.
- Push = in_valid & in_ready.
  - Asserts the enable of entry wr_ptr only. All other entries hold.
  - wr_ptr increments mod 4.
- Pop = out_valid & out_ready.
  - rd_ptr increments mod 4; out_col increments mod 4.
- in_ready = (level != 4). It does not depend on out_ready, so there is no combinational ready path through the block. When full, a simultaneous pop does not enable a push in that cycle.
- out_valid = (level != 0). There is no bypass: a column accepted at edge N is first visible at out_valid/out_data after edge N. Minimum latency is 1 cycle.
- Level update:
  - push and pop together: level unchanged, both pointers advance.
  - push only: +1.
  - pop only: -1.
  - Never exceeds 4 or goes below 0.
- out_data = entry[rd_ptr], selected by a masked mux tree. The select comes from rd_ptr only and is never derived from data.
- Pointer wrap: pointers are 2-bit and wrap 3->0. Full versus empty is decided by level, not pointer equality.
- Masking rules:
  - No share of in_data or out_data influences any control signal.
  - Entries are never cleared, XORed or combined across shares.
  - Shares pass through unchanged, bit-for-bit.
- Handshake stability rules (verification checks these; the block does not enforce them):
  - Upstream must hold in_valid/in_data until accepted.
  - The block holds out_valid/out_data stable until popped, except on reset or flush.

Test Plan:
- Reset: drive nrst=0 for 2 cycles with in_valid=1, then release -> level=0, in_ready=1, out_valid=0, out_col=0; no entry enable asserted during reset.
- Fill and drain (d=2): push 4 columns with shares {A_i, B_i} while out_ready=0.
  - After the 4th push: level=4, in_ready=0.
  - Then set out_ready=1: the 4 columns come out in order, shares unchanged, out_col=0,1,2,3, out_last only on the 4th, then out_valid=0.
- Streaming: in_valid=out_ready=1 for 12 cycles -> level stays 1 after the first cycle, one column per cycle, pointers wrap 3 times, out_col cycles 0..3.
- Full plus simultaneous events: at level=4, in_valid=1 and out_ready=1 -> pop occurs, push is refused that cycle (level=3). The next cycle both occur (level stays 3).
- Mid-operation flush: at level=3, assert flush with in_valid=1 -> next cycle level=0, out_valid=0; the following push is returned as the first output with out_col=0.
- Share independence: repeat the fill-and-drain stimulus with different random masks but identical control stimulus -> all control outputs are cycle-identical.
